// File: rtl/mult_karatsuba_seq_if.sv
// mult_karatsuba_seq_if: start/done multiplier handshake between controller and multiplier
interface mult_karatsuba_seq_if #(parameter int WIDTH = 32);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] p;
  modport master (output start, a, b, input busy, done, p);
  modport slave (input start, a, b, output busy, done, p);
endinterface

// File: rtl/mult_karatsuba_seq.sv
// mult_karatsuba_seq: three-step Karatsuba multiplier sharing one (H+1)x(H+1) multiplier
module mult_karatsuba_seq #(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 0
) (
  input logic clk,
  input logic rst_n,
  mult_karatsuba_seq_if.slave bus
);
  localparam int H  = WIDTH / 2;
  localparam int W2 = 2 * WIDTH;
  typedef enum logic [2:0] {IDLE, MUL_LO, MUL_HI, MUL_MID, COMBINE} state_t;
  state_t           state;
  logic [WIDTH-1:0] ar, br, a_mag, b_mag;
  logic             neg, done_r;
  logic [2*H-1:0]   z0, z2;
  logic [2*H+1:0]   z1, mid, mp;
  logic [H:0]       mx, my;
  logic [W2-1:0]    prod, p_r;
  always_comb begin
    a_mag = (SIGNED != 0 && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag = (SIGNED != 0 && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    // outside MUL_LO/MUL_HI the carry-kept half sums feed the shared multiplier
    mx = state == MUL_LO ? {1'b0, ar[H-1:0]} : state == MUL_HI ? {1'b0, ar[WIDTH-1:H]} :
         {1'b0, ar[H-1:0]} + {1'b0, ar[WIDTH-1:H]};
    my = state == MUL_LO ? {1'b0, br[H-1:0]} : state == MUL_HI ? {1'b0, br[WIDTH-1:H]} :
         {1'b0, br[H-1:0]} + {1'b0, br[WIDTH-1:H]};
    mp = mx * my;
    mid = z1 - {2'b0, z2} - {2'b0, z0};
    prod = {z2, {WIDTH{1'b0}}} + (W2'(mid) << H) + W2'(z0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ar     <= '0;
      br     <= '0;
      neg    <= 1'b0;
      z0     <= '0;
      z2     <= '0;
      z1     <= '0;
      p_r    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          ar    <= a_mag;
          br    <= b_mag;
          neg   <= SIGNED != 0 && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          state <= MUL_LO;
        end
        MUL_LO: begin
          z0    <= mp[2*H-1:0];
          state <= MUL_HI;
        end
        MUL_HI: begin
          z2    <= mp[2*H-1:0];
          state <= MUL_MID;
        end
        MUL_MID: begin
          z1    <= mp;
          state <= COMBINE;
        end
        COMBINE: begin
          p_r    <= neg ? -prod : prod;
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.done = done_r;
  assign bus.p    = p_r;
endmodule
